// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, branch flushes, and memory-wait freezes.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_ctrl #(
  parameter logic [3:0]  LOAD_TYPE    = 4'd1,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idUsesRS,
  input  logic        idUsesRT,
  input  logic [4:0]  idRS,
  input  logic [4:0]  idRT,
  input  logic [3:0]  exInstrType,
  input  logic [4:0]  exRegDest,
  input  logic        branchTaken,
  input  logic        memBusy,
  output logic        stallPC,
  output logic        stallIFID,
  output logic        stallIDEX,
  output logic        stallEXMEM,
  output logic        bubbleIDEX,
  output logic        bubbleMEMWB,
  output logic        flushIFID,
  output logic        flushIDEX,
  output logic [15:0] stallCycles
);

  typedef enum logic [1:0] {RUN, BUBBLE, FLUSH, MEMWAIT} state_t;

  localparam logic [1:0] LB_INIT = 2'(LOAD_BUBBLES - 1);
  localparam logic [1:0] FC_INIT = 2'(FLUSH_CYCLES - 1);

  state_t     r_state, w_next_state;
  state_t     r_saved, w_next_saved;
  logic [1:0] r_cnt, w_next_cnt;

  logic w_load_use;
  logic w_freeze;
  logic w_bubble;
  logic w_flush_ifid;
  logic w_flush_idex;

  assign w_load_use = (exInstrType == LOAD_TYPE) && (exRegDest != 5'd0) &&
                      ((idUsesRS && (exRegDest == idRS)) ||
                       (idUsesRT && (exRegDest == idRT)));

  always_comb begin
    w_freeze     = 1'b0;
    w_bubble     = 1'b0;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_saved = r_saved;
    case (r_state)
      RUN: begin
        if (memBusy) begin
          w_freeze     = 1'b1;
          w_next_saved = RUN;
          w_next_state = MEMWAIT;
        end else if (branchTaken) begin
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_next_cnt   = FC_INIT;
            w_next_state = FLUSH;
          end
        end else if (w_load_use) begin
          w_bubble = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            w_next_cnt   = LB_INIT;
            w_next_state = BUBBLE;
          end
        end
      end
      BUBBLE: begin
        if (memBusy) begin
          w_freeze     = 1'b1;
          w_next_saved = BUBBLE;
          w_next_state = MEMWAIT;
        end else begin
          w_bubble   = 1'b1;
          w_next_cnt = r_cnt - 2'd1;
          if (r_cnt == 2'd1) w_next_state = RUN;
        end
      end
      FLUSH: begin
        if (memBusy) begin
          w_freeze     = 1'b1;
          w_next_saved = FLUSH;
          w_next_state = MEMWAIT;
        end else begin
          w_flush_ifid = 1'b1;
          w_next_cnt   = r_cnt - 2'd1;
          if (r_cnt == 2'd1) w_next_state = RUN;
        end
      end
      MEMWAIT: begin
        // Return cycle is silent; savedState's rules apply from the next cycle.
        if (memBusy) w_freeze = 1'b1;
        else         w_next_state = r_saved;
      end
      default: w_next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_saved <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_saved <= w_next_saved;
      r_cnt   <= w_next_cnt;
    end
  end

  // Mealy outputs are forced low while reset is held, regardless of inputs.
  assign stallPC     = ~rst & (w_freeze | w_bubble);
  assign stallIFID   = ~rst & (w_freeze | w_bubble);
  assign stallIDEX   = ~rst & w_freeze;
  assign stallEXMEM  = ~rst & w_freeze;
  assign bubbleIDEX  = ~rst & w_bubble;
  assign bubbleMEMWB = ~rst & w_freeze;
  assign flushIFID   = ~rst & w_flush_ifid;
  assign flushIDEX   = ~rst & w_flush_idex;

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_stall_cnt <= '0;
    else if (stallPC && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stallCycles = r_stall_cnt;
`else
  assign stallCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances with different bubble/flush depths share stimulus.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       idUsesRS, idUsesRT;
  logic [4:0] idRS, idRT;
  logic [3:0] exInstrType;
  logic [4:0] exRegDest;
  logic       branchTaken, memBusy;

  // {stallPC,stallIFID,stallIDEX,stallEXMEM,bubbleIDEX,bubbleMEMWB,flushIFID,flushIDEX}
  logic [7:0]  oA, oB, oC;
  logic [15:0] sA, sB, sC;

  localparam logic [7:0] IDLE  = 8'h00;
  localparam logic [7:0] LDU   = 8'hC8;
  localparam logic [7:0] FRZ   = 8'hF4;
  localparam logic [7:0] FL2   = 8'h03;
  localparam logic [7:0] FL1   = 8'h02;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.LOAD_TYPE(4'd1), .LOAD_BUBBLES(1), .FLUSH_CYCLES(1)) dA (
    .clk(clk), .rst(rst), .idUsesRS(idUsesRS), .idUsesRT(idUsesRT), .idRS(idRS), .idRT(idRT),
    .exInstrType(exInstrType), .exRegDest(exRegDest), .branchTaken(branchTaken), .memBusy(memBusy),
    .stallPC(oA[7]), .stallIFID(oA[6]), .stallIDEX(oA[5]), .stallEXMEM(oA[4]),
    .bubbleIDEX(oA[3]), .bubbleMEMWB(oA[2]), .flushIFID(oA[1]), .flushIDEX(oA[0]),
    .stallCycles(sA));

  hazard_ctrl #(.LOAD_TYPE(4'd1), .LOAD_BUBBLES(2), .FLUSH_CYCLES(3)) dB (
    .clk(clk), .rst(rst), .idUsesRS(idUsesRS), .idUsesRT(idUsesRT), .idRS(idRS), .idRT(idRT),
    .exInstrType(exInstrType), .exRegDest(exRegDest), .branchTaken(branchTaken), .memBusy(memBusy),
    .stallPC(oB[7]), .stallIFID(oB[6]), .stallIDEX(oB[5]), .stallEXMEM(oB[4]),
    .bubbleIDEX(oB[3]), .bubbleMEMWB(oB[2]), .flushIFID(oB[1]), .flushIDEX(oB[0]),
    .stallCycles(sB));

  hazard_ctrl #(.LOAD_TYPE(4'd1), .LOAD_BUBBLES(3), .FLUSH_CYCLES(2)) dC (
    .clk(clk), .rst(rst), .idUsesRS(idUsesRS), .idUsesRT(idUsesRT), .idRS(idRS), .idRT(idRT),
    .exInstrType(exInstrType), .exRegDest(exRegDest), .branchTaken(branchTaken), .memBusy(memBusy),
    .stallPC(oC[7]), .stallIFID(oC[6]), .stallIDEX(oC[5]), .stallEXMEM(oC[4]),
    .bubbleIDEX(oC[3]), .bubbleMEMWB(oC[2]), .flushIFID(oC[1]), .flushIDEX(oC[0]),
    .stallCycles(sC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    idUsesRS = 1'b0; idUsesRT = 1'b0; idRS = 5'd0; idRT = 5'd0;
    exInstrType = 4'd0; exRegDest = 5'd0; branchTaken = 1'b0; memBusy = 1'b0;
  endtask

  // EX load writing r5, ID reading r5 through RS.
  task automatic set_load();
    exInstrType = 4'd1; exRegDest = 5'd5; idUsesRS = 1'b1; idRS = 5'd5;
    idUsesRT = 1'b0; idRT = 5'd0;
  endtask

  task automatic apply_reset();
    set_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_load(); branchTaken = 1'b1; memBusy = 1'b1;
    @(negedge clk);
    checks++; if (oA !== IDLE) begin failures++; $display("FAIL reset_outA: got %h expected %h", oA, IDLE); end
    checks++; if (oB !== IDLE) begin failures++; $display("FAIL reset_outB: got %h expected %h", oB, IDLE); end
    checks++; if (oC !== IDLE) begin failures++; $display("FAIL reset_outC: got %h expected %h", oC, IDLE); end
    checks++; if (sB !== 16'd0) begin failures++; $display("FAIL reset_cnt: got %h expected 0000", sB); end
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (oB !== IDLE) begin failures++; $display("FAIL reset_release: got %h expected %h", oB, IDLE); end
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [7:0] expA [3] = '{LDU, IDLE, IDLE};
    logic [7:0] expB [3] = '{LDU, LDU, IDLE};
    logic [7:0] expC [4] = '{LDU, LDU, LDU, IDLE};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_load(); else set_idle();
      @(negedge clk);
      if (i < 3) begin
        checks++; if (oA !== expA[i]) begin failures++; $display("FAIL load1_c%0d: got %h expected %h", i, oA, expA[i]); end
        checks++; if (oB !== expB[i]) begin failures++; $display("FAIL load2_c%0d: got %h expected %h", i, oB, expB[i]); end
      end
      checks++; if (oC !== expC[i]) begin failures++; $display("FAIL load3_c%0d: got %h expected %h", i, oC, expC[i]); end
      next_cycle();
    end
  endtask

  task automatic test_load_negatives();
    apply_reset();
    exInstrType = 4'd1; exRegDest = 5'd0; idUsesRS = 1'b1; idRS = 5'd0; idUsesRT = 1'b1; idRT = 5'd0;
    @(negedge clk);
    checks++; if (oB !== IDLE) begin failures++; $display("FAIL load_r0: got %h expected %h", oB, IDLE); end
    next_cycle();
    exRegDest = 5'd7; idRS = 5'd3; idRT = 5'd7; idUsesRT = 1'b0;
    @(negedge clk);
    checks++; if (oB !== IDLE) begin failures++; $display("FAIL load_rt_unused: got %h expected %h", oB, IDLE); end
    next_cycle();
    exInstrType = 4'd2; idUsesRT = 1'b1;
    @(negedge clk);
    checks++; if (oB !== IDLE) begin failures++; $display("FAIL nonload_type: got %h expected %h", oB, IDLE); end
    next_cycle();
    exInstrType = 4'd1;
    @(negedge clk);
    checks++; if (oB !== LDU) begin failures++; $display("FAIL load_rt_c0: got %h expected %h", oB, LDU); end
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++; if (oB !== LDU) begin failures++; $display("FAIL load_rt_c1: got %h expected %h", oB, LDU); end
    next_cycle();
    @(negedge clk);
    checks++; if (oB !== IDLE) begin failures++; $display("FAIL load_rt_c2: got %h expected %h", oB, IDLE); end
    next_cycle();
  endtask

  task automatic test_flush();
    logic [7:0] expA [4] = '{FL2, IDLE, IDLE, IDLE};
    logic [7:0] expB [4] = '{FL2, FL1, FL1, IDLE};
    logic [7:0] expC [4] = '{FL2, FL1, IDLE, IDLE};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      branchTaken = (i == 0);
      @(negedge clk);
      checks++; if (oA !== expA[i]) begin failures++; $display("FAIL flush1_c%0d: got %h expected %h", i, oA, expA[i]); end
      checks++; if (oB !== expB[i]) begin failures++; $display("FAIL flush3_c%0d: got %h expected %h", i, oB, expB[i]); end
      checks++; if (oC !== expC[i]) begin failures++; $display("FAIL flush2_c%0d: got %h expected %h", i, oC, expC[i]); end
      next_cycle();
    end
  endtask

  task automatic test_branch_and_load();
    logic [7:0] expB [4] = '{FL2, FL1, FL1, IDLE};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      // Load-use stays asserted into FLUSH, where it must be ignored.
      if (i < 3) set_load(); else set_idle();
      branchTaken = (i == 0);
      @(negedge clk);
      if (i == 0) begin
        checks++; if (oA !== FL2) begin failures++; $display("FAIL br_ld_A: got %h expected %h", oA, FL2); end
      end
      if (i < 3) begin
        checks++; if (oB !== expB[i]) begin failures++; $display("FAIL br_ld_B_c%0d: got %h expected %h", i, oB, expB[i]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_mem_in_bubble();
    logic [7:0] expC [9] = '{LDU, FRZ, FRZ, FRZ, FRZ, IDLE, LDU, LDU, IDLE};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 0) set_load(); else set_idle();
      memBusy = (i >= 1 && i <= 4);
      @(negedge clk);
      checks++; if (oC !== expC[i]) begin failures++; $display("FAIL mem_bubble_c%0d: got %h expected %h", i, oC, expC[i]); end
      next_cycle();
    end
  endtask

  task automatic test_mem_priority();
    logic [7:0] expB [6] = '{FRZ, IDLE, FL2, FL1, FL1, IDLE};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      memBusy     = (i == 0);
      branchTaken = (i <= 2);
      @(negedge clk);
      checks++; if (oB !== expB[i]) begin failures++; $display("FAIL mem_branch_c%0d: got %h expected %h", i, oB, expB[i]); end
      next_cycle();
    end
  endtask

  task automatic test_reset_in_flush();
    apply_reset();
    branchTaken = 1'b1;
    @(negedge clk);
    checks++; if (oB !== FL2) begin failures++; $display("FAIL rstflush_c0: got %h expected %h", oB, FL2); end
    next_cycle();
    branchTaken = 1'b0;
    #2;
    checks++; if (oB !== FL1) begin failures++; $display("FAIL rstflush_pre: got %h expected %h", oB, FL1); end
    rst = 1'b1;
    #1;
    checks++; if (oB !== IDLE) begin failures++; $display("FAIL rstflush_async: got %h expected %h", oB, IDLE); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (oB !== IDLE) begin failures++; $display("FAIL rstflush_run0: got %h expected %h", oB, IDLE); end
    next_cycle();
    @(negedge clk);
    checks++; if (oB !== IDLE) begin failures++; $display("FAIL rstflush_run1: got %h expected %h", oB, IDLE); end
    next_cycle();
  endtask

  task automatic test_stall_count();
`ifdef HAZARD_STALL_COUNT_EN
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      set_load();
      next_cycle();
      set_idle();
      next_cycle();
      next_cycle();
    end
    @(negedge clk);
    checks++; if (sB !== 16'd6) begin failures++; $display("FAIL stallcnt_6: got %0d expected 6", sB); end
    next_cycle();
    memBusy = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    checks++; if (sB !== 16'hFFFF) begin failures++; $display("FAIL stallcnt_sat: got %h expected ffff", sB); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sB !== 16'hFFFF) begin failures++; $display("FAIL stallcnt_hold: got %h expected ffff", sB); end
    set_idle();
`else
    @(negedge clk);
    checks++; if (sA !== 16'd0) begin failures++; $display("FAIL stallcnt_offA: got %h expected 0000", sA); end
    checks++; if (sB !== 16'd0) begin failures++; $display("FAIL stallcnt_offB: got %h expected 0000", sB); end
    checks++; if (sC !== 16'd0) begin failures++; $display("FAIL stallcnt_offC: got %h expected 0000", sC); end
    next_cycle();
`endif
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_load_negatives();
    test_flush();
    test_branch_and_load();
    test_mem_in_bubble();
    test_mem_priority();
    test_reset_in_flush();
    test_stall_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
